// File: rtl/line_fill_axi_reader_if.sv
// line_fill_axi_reader_if: AXI4 read-address and read-data channels of the line-fill back end.
interface line_fill_axi_reader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) ();
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/line_fill_axi_reader.sv
// line_fill_axi_reader: fetches one cache line with a single INCR burst and refetches it on any error response.
module line_fill_axi_reader #(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int BE_ADDR_W  = FE_ADDR_W,
    parameter int BE_DATA_W  = FE_DATA_W,
    parameter int AXI_ID_W   = 1,
    parameter logic [AXI_ID_W-1:0] AXI_ID = '0,
    parameter int WORD_OFF_W = 3,
    parameter int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
    localparam int FE_BYTE_W   = $clog2(FE_DATA_W / 8),
    localparam int BE_BYTE_W   = $clog2(BE_DATA_W / 8),
    localparam int LINE_ADDR_W = FE_ADDR_W - FE_BYTE_W - WORD_OFF_W,
    localparam int CNT_W       = (LINE2MEM_W > 0) ? LINE2MEM_W : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   replace_valid,
    input  logic [LINE_ADDR_W-1:0] replace_addr,
    output logic                   replace,
    output logic                   read_valid,
    output logic [CNT_W-1:0]       read_addr,
    output logic [BE_DATA_W-1:0]   read_data,
    line_fill_axi_reader_if.master m_axi
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             beat_err;
    logic             unused_rid;

    // The burst always covers the whole line starting at its first byte.
    assign m_axi.arid    = AXI_ID;
    assign m_axi.araddr  = BE_ADDR_W'({replace_addr, {(FE_BYTE_W + WORD_OFF_W){1'b0}}});
    assign m_axi.arlen   = 8'((1 << LINE2MEM_W) - 1);
    assign m_axi.arsize  = 3'(BE_BYTE_W);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;

    // Handshake outputs depend on state only, so ready/valid never loop back combinationally.
    assign m_axi.arvalid = (state_q == ADDR);
    assign m_axi.rready  = (state_q == DATA);
    assign replace       = (state_q != IDLE);
    assign read_valid    = (state_q == DATA) && m_axi.rvalid;
    assign read_addr     = (LINE2MEM_W == 0) ? '0 : cnt_q;
    assign read_data     = m_axi.rdata;
    assign beat_err      = (m_axi.rresp != 2'b00);
    assign unused_rid    = ^m_axi.rid;

    // State, beat counter and sticky error flag; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: rlast ends the burst; an error anywhere in it reissues the same line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (replace_valid) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ADDR: begin
                if (m_axi.arready) state_d = DATA;
            end
            DATA: begin
                if (m_axi.rvalid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    err_d = err_q | beat_err;
                    if (m_axi.rlast) begin
                        state_d = (err_q | beat_err) ? ADDR : IDLE;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_line_fill_axi_reader.sv
// tb_line_fill_axi_reader: directed checks of line fills, backpressure, error retry, wide beats and async reset.
module tb_line_fill_axi_reader;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        replace_valid;
    logic [26:0] replace_addr;
    logic        replace, read_valid;
    logic [2:0]  read_addr;
    logic [31:0] read_data;

    logic        w_replace_valid;
    logic [26:0] w_replace_addr;
    logic        w_replace, w_read_valid;
    logic [1:0]  w_read_addr;
    logic [63:0] w_read_data;

    line_fill_axi_reader_if #(.ADDR_W(32), .DATA_W(32), .ID_W(1)) axi ();
    line_fill_axi_reader_if #(.ADDR_W(32), .DATA_W(64), .ID_W(1)) w_axi ();

    line_fill_axi_reader dut (
        .clk(clk), .reset_n(reset_n), .replace_valid(replace_valid), .replace_addr(replace_addr),
        .replace(replace), .read_valid(read_valid), .read_addr(read_addr), .read_data(read_data),
        .m_axi(axi.master)
    );

    line_fill_axi_reader #(.BE_DATA_W(64)) dut_w (
        .clk(clk), .reset_n(reset_n), .replace_valid(w_replace_valid), .replace_addr(w_replace_addr),
        .replace(w_replace), .read_valid(w_read_valid), .read_addr(w_read_addr), .read_data(w_read_data),
        .m_axi(w_axi.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        replace_valid = 0; replace_addr = '0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
        w_replace_valid = 0; w_replace_addr = '0;
        w_axi.arready = 0; w_axi.rid = 0; w_axi.rdata = 0; w_axi.rresp = 0; w_axi.rlast = 0; w_axi.rvalid = 0;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            nxt();
            replace_valid = 1'($urandom); replace_addr = 27'($urandom);
            axi.arready = 1'($urandom); axi.rvalid = 1'($urandom); axi.rlast = 1'($urandom);
            axi.rresp = 2'($urandom); axi.rdata = $urandom;
            #1;
            chk("rst_arvalid", axi.arvalid, 0);
            chk("rst_rready", axi.rready, 0);
            chk("rst_replace", replace, 0);
            chk("rst_read_valid", read_valid, 0);
            chk("rst_read_addr", read_addr, 0);
        end
        nxt();
        reset_n = 1; replace_valid = 0; axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0;
        nxt();

        // nominal fill
        replace_valid = 1; replace_addr = 27'h0123456; axi.arready = 1;
        #1;
        chk("nom_idle_replace", replace, 0);
        chk("nom_idle_arvalid", axi.arvalid, 0);
        nxt();
        replace_valid = 0;
        #1;
        chk("nom_replace", replace, 1);
        chk("nom_arvalid", axi.arvalid, 1);
        chk("nom_araddr", axi.araddr, 32'h02468AC0);
        chk("nom_arlen", axi.arlen, 7);
        chk("nom_arsize", axi.arsize, 2);
        chk("nom_arburst", axi.arburst, 1);
        chk("nom_arlock", axi.arlock, 0);
        chk("nom_arcache", axi.arcache, 4'b0011);
        chk("nom_arprot", axi.arprot, 0);
        chk("nom_arid", axi.arid, 0);
        chk("nom_addr_rready", axi.rready, 0);
        nxt();
        for (int i = 0; i < 8; i++) begin
            axi.arready = 0; axi.rvalid = 1; axi.rdata = i; axi.rresp = 0; axi.rlast = (i == 7);
            #1;
            chk("nom_rready", axi.rready, 1);
            chk("nom_read_valid", read_valid, 1);
            chk("nom_read_addr", read_addr, i);
            chk("nom_read_data", read_data, i);
            chk("nom_beat_arvalid", axi.arvalid, 0);
            chk("nom_beat_replace", replace, 1);
            nxt();
        end
        axi.rvalid = 0; axi.rlast = 0;
        #1;
        chk("nom_done_replace", replace, 0);
        chk("nom_done_rready", axi.rready, 0);
        chk("nom_done_read_valid", read_valid, 0);
        nxt();

        // backpressure: late arready, rvalid every other cycle
        replace_valid = 1; replace_addr = 27'h7654321;
        nxt();
        replace_valid = 0;
        for (int k = 0; k < 5; k++) begin
            axi.arready = (k == 4);
            #1;
            chk("bp_arvalid", axi.arvalid, 1);
            chk("bp_araddr", axi.araddr, 32'hECA86420);
            chk("bp_rready", axi.rready, 0);
            nxt();
        end
        axi.arready = 0;
        for (int j = 0; j < 16; j++) begin
            axi.rvalid = (j % 2 == 1); axi.rdata = 32'hA0 + j / 2; axi.rlast = (j == 15);
            #1;
            chk("bp_read_valid", read_valid, (j % 2 == 1));
            chk("bp_read_addr", read_addr, j / 2);
            nxt();
        end
        axi.rvalid = 0; axi.rlast = 0;
        #1;
        chk("bp_done_replace", replace, 0);
        nxt();

        // error retry: beat 3 SLVERR
        replace_valid = 1; replace_addr = 27'h0000ABC; axi.arready = 1;
        nxt();
        replace_valid = 0;
        #1;
        chk("err_arvalid", axi.arvalid, 1);
        chk("err_araddr", axi.araddr, 32'h00015780);
        nxt();
        for (int i = 0; i < 8; i++) begin
            axi.rvalid = 1; axi.rresp = (i == 3) ? 2'b10 : 2'b00; axi.rlast = (i == 7);
            #1;
            chk("err_read_valid", read_valid, 1);
            chk("err_read_addr", read_addr, i);
            nxt();
        end
        axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0;
        #1;
        chk("err_retry_arvalid", axi.arvalid, 1);
        chk("err_retry_araddr", axi.araddr, 32'h00015780);
        chk("err_retry_replace", replace, 1);
        nxt();
        for (int i = 0; i < 8; i++) begin
            axi.rvalid = 1; axi.rlast = (i == 7);
            #1;
            chk("err2_read_valid", read_valid, 1);
            chk("err2_read_addr", read_addr, i);
            nxt();
        end
        axi.rvalid = 0; axi.rlast = 0;
        #1;
        chk("err_done_replace", replace, 0);
        chk("err_done_arvalid", axi.arvalid, 0);
        nxt();

        // width ratio: 64-bit back end, 4 beats per line
        w_replace_valid = 1; w_replace_addr = 27'h0123456; w_axi.arready = 1;
        nxt();
        w_replace_valid = 0;
        #1;
        chk("w_arvalid", w_axi.arvalid, 1);
        chk("w_araddr", w_axi.araddr, 32'h02468AC0);
        chk("w_arlen", w_axi.arlen, 3);
        chk("w_arsize", w_axi.arsize, 3);
        nxt();
        for (int i = 0; i < 4; i++) begin
            w_axi.rvalid = 1; w_axi.rdata = {32'hB0 + i, 32'hC0 + i}; w_axi.rlast = (i == 3);
            #1;
            chk("w_read_valid", w_read_valid, 1);
            chk("w_read_addr", w_read_addr, i);
            chk("w_read_data", w_read_data, {32'hB0 + i, 32'hC0 + i});
            nxt();
        end
        w_axi.rvalid = 0; w_axi.rlast = 0;
        #1;
        chk("w_done_replace", w_replace, 0);
        nxt();

        // async reset during beat 4
        replace_valid = 1; replace_addr = 27'h0000001; axi.arready = 1;
        nxt();
        replace_valid = 0;
        nxt();
        for (int i = 0; i < 4; i++) begin
            axi.rvalid = 1; axi.rlast = 0;
            nxt();
        end
        #1;
        chk("ar_pre_read_valid", read_valid, 1);
        chk("ar_pre_read_addr", read_addr, 4);
        reset_n = 0;
        #1;
        chk("ar_read_valid", read_valid, 0);
        chk("ar_rready", axi.rready, 0);
        chk("ar_replace", replace, 0);
        chk("ar_read_addr", read_addr, 0);
        chk("ar_arvalid", axi.arvalid, 0);
        nxt();
        axi.rvalid = 0;
        nxt();
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            nxt();
            #1;
            chk("ar_post_arvalid", axi.arvalid, 0);
            chk("ar_post_replace", replace, 0);
        end
        nxt();
        replace_valid = 1;
        nxt();
        replace_valid = 0;
        #1;
        chk("ar_new_arvalid", axi.arvalid, 1);
        chk("ar_new_araddr", axi.araddr, 32'h00000020);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
